// File: rtl/mc_pwr_pkg.sv
// Shared types for the memory-controller power sequencer: state encoding,
// the five-bit control vector, and the per-state output table.
package mc_pwr_pkg;

   typedef enum logic [3:0] {
      ST_ON, ST_GATE, ST_SAVE, ST_ISO, ST_PDN, ST_OFF,
      ST_PUP, ST_STL, ST_RST, ST_RSTE, ST_FAULT
   } mc_pwr_state_e;

   typedef struct packed {
      logic pwr;
      logic save;
      logic restore;
      logic iso;
      logic clk_gate;
   } mc_pwr_ctrl_t;

   localparam mc_pwr_ctrl_t MC_PWR_CTRL_ON    = '{pwr: 1'b1, save: 1'b0, restore: 1'b1, iso: 1'b0, clk_gate: 1'b1};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_GATE  = '{pwr: 1'b1, save: 1'b0, restore: 1'b1, iso: 1'b0, clk_gate: 1'b0};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_SAVE  = '{pwr: 1'b1, save: 1'b1, restore: 1'b1, iso: 1'b0, clk_gate: 1'b0};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_ISO   = '{pwr: 1'b1, save: 1'b0, restore: 1'b1, iso: 1'b1, clk_gate: 1'b0};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_PDN   = '{pwr: 1'b0, save: 1'b0, restore: 1'b1, iso: 1'b1, clk_gate: 1'b0};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_OFF   = '{pwr: 1'b0, save: 1'b0, restore: 1'b1, iso: 1'b1, clk_gate: 1'b0};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_PUP   = '{pwr: 1'b1, save: 1'b0, restore: 1'b1, iso: 1'b1, clk_gate: 1'b0};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_STL   = '{pwr: 1'b1, save: 1'b0, restore: 1'b1, iso: 1'b1, clk_gate: 1'b0};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_RST   = '{pwr: 1'b1, save: 1'b0, restore: 1'b0, iso: 1'b1, clk_gate: 1'b0};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_RSTE  = '{pwr: 1'b1, save: 1'b0, restore: 1'b1, iso: 1'b1, clk_gate: 1'b0};
   localparam mc_pwr_ctrl_t MC_PWR_CTRL_FAULT = '{pwr: 1'b1, save: 1'b0, restore: 1'b1, iso: 1'b1, clk_gate: 1'b0};

   localparam mc_pwr_ctrl_t MC_PWR_RESET = MC_PWR_CTRL_ON;

   function automatic mc_pwr_ctrl_t mc_pwr_ctrl(input mc_pwr_state_e state);
      case (state)
         ST_ON:    return MC_PWR_CTRL_ON;
         ST_GATE:  return MC_PWR_CTRL_GATE;
         ST_SAVE:  return MC_PWR_CTRL_SAVE;
         ST_ISO:   return MC_PWR_CTRL_ISO;
         ST_PDN:   return MC_PWR_CTRL_PDN;
         ST_OFF:   return MC_PWR_CTRL_OFF;
         ST_PUP:   return MC_PWR_CTRL_PUP;
         ST_STL:   return MC_PWR_CTRL_STL;
         ST_RST:   return MC_PWR_CTRL_RST;
         ST_RSTE:  return MC_PWR_CTRL_RSTE;
         default:  return MC_PWR_CTRL_FAULT;
      endcase
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/mc_pwr_ack_sync.sv
// Two-flop synchroniser for the domain supply acknowledge. Resets high so a
// powered domain is assumed until the real ack has been sampled.
module mc_pwr_ack_sync (
   input  logic clk,
   input  logic reset,
   input  logic ack,
   output logic ack_sync
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so both flops
   // sample the pre-edge values and the chain really is two stages deep.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta     <= 1'b1;
         ack_sync <= 1'b1;
      end else begin
         meta     <= ack;
         ack_sync <= meta;
      end
   end

endmodule

// File: rtl/mc_power_sequencer.sv
// Power-down / power-up sequencer for the memory-controller domain. All
// outputs are registered from the next-state decode.
module mc_power_sequencer #(
   parameter int OFF_MIN     = 16,
   parameter int SETTLE      = 4,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic sleep_req,
   input  logic wake_req,
   input  logic mc_pwr_ack,
   output logic mc_pwr,
   output logic mc_save,
   output logic mc_restore,
   output logic mc_iso,
   output logic mc_clk_gate,
   output logic mc_off,
   output logic busy,
   output logic err
);

   import mc_pwr_pkg::*;

   localparam int TW = $clog2(max3(OFF_MIN, SETTLE, ACK_TIMEOUT)) + 1;
   typedef logic [TW-1:0] timer_t;

   localparam timer_t OFF_LAST    = timer_t'(OFF_MIN - 1);
   localparam timer_t SETTLE_LAST = timer_t'(SETTLE - 1);
   localparam timer_t ACK_LAST    = timer_t'(ACK_TIMEOUT - 1);

   mc_pwr_state_e state, state_next;
   timer_t        timer;
   logic          err_next;
   logic          ack_sync;

   mc_pwr_ack_sync u_ack_sync (
      .clk      (clk),
      .reset    (reset),
      .ack      (mc_pwr_ack),
      .ack_sync (ack_sync)
   );

   // Timer restarts at 0 on every state change and saturates instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_ON;
         timer <= '0;
         {mc_pwr, mc_save, mc_restore, mc_iso, mc_clk_gate} <= MC_PWR_RESET;
         mc_off <= 1'b0;
         busy   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next != state)
            timer <= '0;
         else if (timer != '1)
            timer <= timer + TW'(1);
         {mc_pwr, mc_save, mc_restore, mc_iso, mc_clk_gate} <= mc_pwr_ctrl(state_next);
         mc_off <= (state_next == ST_OFF);
         busy   <= (state_next != ST_ON) && (state_next != ST_OFF);
         err    <= err_next;
      end
   end

   // NOTE: every signal written here gets its default first, so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      err_next   = err;
      case (state)
         ST_ON:   if (sleep_req) state_next = ST_GATE;
         ST_GATE: state_next = ST_SAVE;
         ST_SAVE: state_next = ST_ISO;
         ST_ISO:  state_next = ST_PDN;
         ST_PDN: begin
            if (!ack_sync) begin
               state_next = ST_OFF;
            end else if (timer >= ACK_LAST) begin
               state_next = ST_OFF;
               err_next   = 1'b1;
            end
         end
         ST_OFF:  if (timer >= OFF_LAST && wake_req) state_next = ST_PUP;
         ST_PUP: begin
            if (ack_sync) begin
               state_next = ST_STL;
            end else if (timer >= ACK_LAST) begin
               state_next = ST_FAULT;
               err_next   = 1'b1;
            end
         end
         // Losing the supply while settling is treated like a missed ack.
         ST_STL: begin
            if (!ack_sync) begin
               state_next = ST_FAULT;
               err_next   = 1'b1;
            end else if (timer >= SETTLE_LAST) begin
               state_next = ST_RST;
            end
         end
         ST_RST:  state_next = ST_RSTE;
         ST_RSTE: state_next = ST_ON;
         default: state_next = ST_FAULT;
      endcase
   end

endmodule

// File: tb/tb_mc_power_sequencer.sv
// Self-checking bench: per-cycle expected output trace derived from the
// sequencing rules, with a delayed-ack supply model.
module tb_mc_power_sequencer;

   localparam int OFF_MIN     = 16;
   localparam int SETTLE      = 4;
   localparam int ACK_TIMEOUT = 64;

   // Control vectors {pwr, save, restore, iso, clk_gate}
   localparam logic [4:0] C_ON    = 5'b10101;
   localparam logic [4:0] C_GATE  = 5'b10100;
   localparam logic [4:0] C_SAVE  = 5'b11100;
   localparam logic [4:0] C_CLAMP = 5'b10110;
   localparam logic [4:0] C_DOWN  = 5'b00110;
   localparam logic [4:0] C_RST   = 5'b10010;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sleep_req = 1'b0;
   logic wake_req = 1'b0;
   logic mc_pwr_ack;
   logic mc_pwr, mc_save, mc_restore, mc_iso, mc_clk_gate, mc_off, busy, err;

   int tests_run = 0;
   int tests_failed = 0;
   bit err_model = 1'b0;

   // Supply model: ack follows mc_pwr after ack_delay falling edges unless forced.
   logic [7:0] hist = '1;
   int ack_delay = 3;
   int ack_mode = 0; // 0 follow, 1 stuck high, 2 stuck low
   assign mc_pwr_ack = (ack_mode == 0) ? hist[ack_delay-1] : (ack_mode == 1);

   always #5 clk = ~clk;
   always @(negedge clk) hist <= {hist[6:0], mc_pwr};

   mc_power_sequencer #(.OFF_MIN(OFF_MIN), .SETTLE(SETTLE), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .sleep_req   (sleep_req),
      .wake_req    (wake_req),
      .mc_pwr_ack  (mc_pwr_ack),
      .mc_pwr      (mc_pwr),
      .mc_save     (mc_save),
      .mc_restore  (mc_restore),
      .mc_iso      (mc_iso),
      .mc_clk_gate (mc_clk_gate),
      .mc_off      (mc_off),
      .busy        (busy),
      .err         (err)
   );

   logic [7:0] obs;
   assign obs = {mc_pwr, mc_save, mc_restore, mc_iso, mc_clk_gate, mc_off, busy, err};

   task automatic check(input string tag, input logic [7:0] obs_v, input logic [7:0] exp_v);
      tests_run++;
      assert (obs_v === exp_v) else begin
         tests_failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check("inv_pwr_iso", {7'd0, mc_pwr | mc_iso}, 8'd1);
         check("inv_save_gate", {7'd0, !mc_save | !mc_clk_gate}, 8'd1);
      end
   end

   function automatic logic [7:0] expv(input logic [4:0] c, input bit off, input bit bsy, input bit e);
      return {c, off, bsy, e};
   endfunction

   task automatic idle_check(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s[%0d]", name, i), obs, expv(C_ON, 1'b0, 1'b0, err_model));
         wake_req = 1'($urandom_range(0, 1));
      end
      wake_req = 1'b0;
   endtask

   task automatic do_reset(input string name);
      #2;
      reset = 1'b1;
      sleep_req = 1'b0;
      wake_req = 1'b0;
      ack_mode = 0;
      err_model = 1'b0;
      #1;
      check(name, obs, expv(C_ON, 1'b0, 1'b0, 1'b0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle_check({name, "_idle"}, 12);
   endtask

   // One sleep request from ON. Index k is the state after the k-th edge,
   // counting the edge that samples sleep_req as k=0. abort: 1 = reset in
   // SAVE, 2 = reset on the first STL cycle.
   task automatic run_seq(input string name, input int d, input int w, input bit early,
                          input int hold_pct, input bit both, input bit pdn_stuck,
                          input bit pup_stuck, input bit glitch, input int abort);
      int pdn_len, off_start, off_len, pup_start, stl_start, rst_idx, on_idx;
      int fault_start, total, hold, abort_idx, j;
      bit faulty, e;
      logic [7:0] ev;
      faulty    = pup_stuck || glitch;
      pdn_len   = pdn_stuck ? ACK_TIMEOUT : d + 2;
      off_start = 3 + pdn_len;
      off_len   = (w + 1 > OFF_MIN) ? w + 1 : OFF_MIN;
      pup_start = off_start + off_len;
      stl_start = pup_start + d + 2;
      rst_idx   = stl_start + SETTLE;
      on_idx    = rst_idx + 2;
      fault_start = pup_stuck ? pup_start + ACK_TIMEOUT : stl_start + 3;
      total     = pup_stuck ? fault_start + 200 : (glitch ? fault_start + 20 : on_idx + 4);
      hold      = (on_idx * hold_pct) / 100;
      abort_idx = (abort == 1) ? 1 : ((abort == 2) ? stl_start : -1);

      #2;
      ack_delay = d;
      ack_mode  = pdn_stuck ? 1 : 0;
      sleep_req = 1'b1;
      wake_req  = both;
      for (int k = 0; k < total; k++) begin
         @(posedge clk);
         #1;
         e = err_model || (pdn_stuck && k >= off_start) || (faulty && k >= fault_start);
         if (k == 0)                ev = expv(C_GATE, 1'b0, 1'b1, e);
         else if (k == 1)           ev = expv(C_SAVE, 1'b0, 1'b1, e);
         else if (k == 2)           ev = expv(C_CLAMP, 1'b0, 1'b1, e);
         else if (k < off_start)    ev = expv(C_DOWN, 1'b0, 1'b1, e);
         else if (k < pup_start)    ev = expv(C_DOWN, 1'b1, 1'b0, e);
         else if (faulty)           ev = expv(C_CLAMP, 1'b0, 1'b1, e);
         else if (k < rst_idx)      ev = expv(C_CLAMP, 1'b0, 1'b1, e);
         else if (k == rst_idx)     ev = expv(C_RST, 1'b0, 1'b1, e);
         else if (k == rst_idx + 1) ev = expv(C_CLAMP, 1'b0, 1'b1, e);
         else                       ev = expv(C_ON, 1'b0, 1'b0, e);
         check($sformatf("%s[%0d]", name, k), obs, ev);

         // Inputs set now are seen in the cycle of state k.
         sleep_req = (k < hold);
         if (k >= off_start && k < pup_start) begin
            j = k - off_start;
            wake_req = (j >= w) || (early && w > 5 && j >= 1 && j <= 3);
         end else begin
            wake_req = 1'($urandom_range(0, 1));
         end
         if (pdn_stuck && k == off_start - 1) ack_mode = 0;
         if (pup_stuck && k == off_start) ack_mode = 2;
         if (glitch && k == stl_start) ack_mode = 2;
         if (k == total - 1) err_model = e;
         if (k == abort_idx) break;
      end
      sleep_req = 1'b0;
      wake_req  = 1'b0;
      if (abort != 0) do_reset({name, "_abort"});
   endtask

   initial begin
      @(negedge clk);
      check("reset_values", obs, expv(C_ON, 1'b0, 1'b0, 1'b0));
      reset = 1'b0;
      idle_check("idle", 100);

      run_seq("normal", 3, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_seq("early_wake", 3, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_seq("wake_dropped", 2, 20, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_seq("both_req", 4, 5, 1'b0, 100, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      for (int r = 0; r < 6; r++) begin
         run_seq($sformatf("rand%0d", r), int'($urandom_range(1, 6)), int'($urandom_range(0, 24)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 100)), 1'($urandom_range(0, 1)),
                 1'b0, 1'b0, 1'b0, 0);
         idle_check($sformatf("rand%0d_gap", r), int'($urandom_range(1, 5)));
      end

      run_seq("pdn_stuck", 3, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      run_seq("after_timeout", 3, 4, 1'b0, 50, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      do_reset("reset_clears_err");

      run_seq("pup_stuck", 3, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      do_reset("fault_reset");

      run_seq("stl_glitch", 3, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      do_reset("glitch_reset");

      run_seq("reset_in_save", 3, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      run_seq("reset_in_stl", 5, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
      run_seq("final", 1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
